// File: rtl/thermo_enc_seq_pkg.sv
// Shared definitions for the bit-serial thermometer encoder:
// FSM state encoding and default geometry.
package thermo_enc_seq_pkg;

    // FSM state encoding (ST_IDLE=0, ST_SHIFT=1, ST_DONE=2)
    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_SHIFT = 2'd1,
        ST_DONE  = 2'd2
    } state_t;

    // Default output word width and count input width
    localparam int DEF_WIDTH = 8;
    localparam int DEF_CNT_W = 4;

endpackage : thermo_enc_seq_pkg

// File: rtl/thermo_enc_seq_ones_count_chk.sv
// ones_count_chk: parametric combinational popcount used by the
// thermo_enc_seq self-check. Only compiled when THERMO_ENC_SELFCHECK_EN
// is defined, so the default build carries no checker logic at all.
`ifdef THERMO_ENC_SELFCHECK_EN
module ones_count_chk #(
    parameter int WIDTH = 8,
    parameter int CNT_W = 4
) (
    input  logic [WIDTH-1:0] data_i,
    output logic [CNT_W-1:0] count_o
);

    // Ripple sum of all bits; CNT_W is wide enough to hold WIDTH
    always_comb begin
        count_o = '0;
        for (int i = 0; i < WIDTH; i++) begin
            count_o = count_o + CNT_W'(data_i[i]);
        end
    end

endmodule : ones_count_chk
`endif

// File: rtl/thermo_enc_seq.sv
// thermo_enc_seq: builds a WIDTH-bit LSB-aligned thermometer word with
// min(cnt_in, WIDTH) ones, one bit per clock through a shift register.
// Accept in IDLE, WIDTH shift cycles, then hold the word in DONE until
// the consumer takes it.
//
// Handshake: a transfer happens on a rising clk edge where valid and
// ready are both high; the producer keeps data stable while valid is
// high and ready is low, and ready never depends on valid.
//
// Optional build macro THERMO_ENC_SELFCHECK_EN adds the chk_err output,
// which flags a popcount mismatch of the emitted word while out_valid=1.
module thermo_enc_seq
    import thermo_enc_seq_pkg::*;
#(
    parameter int WIDTH = DEF_WIDTH,
    parameter int CNT_W = DEF_CNT_W
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [CNT_W-1:0] cnt_in,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out_data,
    output logic             sat,
`ifdef THERMO_ENC_SELFCHECK_EN
    output logic             chk_err,
`endif
    output state_t           dbg_state
);

    localparam int             IDX_W    = $clog2(WIDTH);
    localparam logic [CNT_W-1:0] WIDTH_C  = CNT_W'(WIDTH);
    localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(WIDTH - 1);

    state_t           state_q;
    logic [WIDTH-1:0] shreg_q;
    logic [CNT_W-1:0] rem_q;
    logic [IDX_W-1:0] idx_q;
    logic             sat_q;
    logic             out_valid_q;

    logic             over_d;
    logic [CNT_W-1:0] rem_init_d;

`ifdef THERMO_ENC_SELFCHECK_EN
    logic [CNT_W-1:0] cnt_lat_q;
    logic [CNT_W-1:0] pop_cnt;
`endif

    // Clamp the requested count to WIDTH and flag when clamping occurred
    always_comb begin
        over_d     = (cnt_in > WIDTH_C);
        rem_init_d = over_d ? WIDTH_C : cnt_in;
    end

    // Control FSM plus shift register, remaining-ones and bit-index counters
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= ST_IDLE;
            shreg_q     <= '0;
            rem_q       <= '0;
            idx_q       <= '0;
            sat_q       <= 1'b0;
            out_valid_q <= 1'b0;
`ifdef THERMO_ENC_SELFCHECK_EN
            cnt_lat_q   <= '0;
`endif
        end else begin
            case (state_q)
                ST_IDLE: begin
                    // in_ready is high whenever we are here out of reset
                    if (in_valid) begin
                        rem_q   <= rem_init_d;
                        sat_q   <= over_d;
                        shreg_q <= '0;
                        idx_q   <= '0;
`ifdef THERMO_ENC_SELFCHECK_EN
                        cnt_lat_q <= rem_init_d;
`endif
                        state_q <= ST_SHIFT;
                    end
                end
                ST_SHIFT: begin
                    // Ones enter at the MSB first, so after WIDTH shifts they
                    // have walked down to bits [n-1:0]
                    shreg_q <= {(rem_q != '0), shreg_q[WIDTH-1:1]};
                    if (rem_q != '0) begin
                        rem_q <= rem_q - CNT_W'(1);
                    end
                    if (idx_q == IDX_LAST) begin
                        state_q     <= ST_DONE;
                        out_valid_q <= 1'b1;
                    end else begin
                        idx_q <= idx_q + IDX_W'(1);
                    end
                end
                ST_DONE: begin
                    if (out_ready) begin
                        state_q     <= ST_IDLE;
                        out_valid_q <= 1'b0;
                    end
                end
                default: begin
                    state_q     <= ST_IDLE;
                    out_valid_q <= 1'b0;
                end
            endcase
        end
    end

    // Output view: nothing leaks from the shift register outside DONE
    always_comb begin
        in_ready  = (state_q == ST_IDLE) && !rst;
        out_valid = out_valid_q;
        out_data  = out_valid_q ? shreg_q : '0;
        sat       = out_valid_q & sat_q;
        dbg_state = state_q;
    end

`ifdef THERMO_ENC_SELFCHECK_EN
    ones_count_chk #(
        .WIDTH (WIDTH),
        .CNT_W (CNT_W)
    ) u_ones_count_chk (
        .data_i  (shreg_q),
        .count_o (pop_cnt)
    );

    // Flag a word whose popcount disagrees with the latched clamped count
    always_comb begin
        chk_err = out_valid_q && (pop_cnt != cnt_lat_q);
    end
`endif

endmodule : thermo_enc_seq

// File: tb/tb_thermo_enc_seq.sv
// Testbench for thermo_enc_seq: directed steps, scoreboard queue of
// expected {sat, data} pushed at accept and popped when out_valid rises.
module tb_thermo_enc_seq;
    import thermo_enc_seq_pkg::*;

    localparam int WIDTH = 8;
    localparam int CNT_W = 4;

    // Clock / reset
    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    logic             in_valid  = 1'b0;
    logic             out_ready = 1'b0;
    logic [CNT_W-1:0] cnt_in    = '0;
    logic             in_ready;
    logic             out_valid;
    logic [WIDTH-1:0] out_data;
    logic             sat;
    state_t           dbg_state;
`ifdef THERMO_ENC_SELFCHECK_EN
    logic             chk_err;
`endif

    thermo_enc_seq #(
        .WIDTH (WIDTH),
        .CNT_W (CNT_W)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .cnt_in    (cnt_in),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_data  (out_data),
        .sat       (sat),
`ifdef THERMO_ENC_SELFCHECK_EN
        .chk_err   (chk_err),
`endif
        .dbg_state (dbg_state)
    );

    // Scoreboard
    int             checks   = 0;
    int             failures = 0;
    logic [WIDTH:0] exp_q[$];

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Inputs change and outputs are sampled 1 time unit after the edge
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic int clamp(input int c);
        return (c > WIDTH) ? WIDTH : c;
    endfunction

    function automatic logic [WIDTH:0] model(input int c);
        logic [WIDTH-1:0] d;
        d = '0;
        for (int i = 0; i < clamp(c); i++) d[i] = 1'b1;
        return {(c > WIDTH), d};
    endfunction

    function automatic int popcount(input logic [WIDTH-1:0] d);
        int n;
        n = 0;
        for (int i = 0; i < WIDTH; i++) n += int'(d[i]);
        return n;
    endfunction

    // Driver: one full transaction; hold = cycles out_ready stays low in
    // DONE, rnd = random out_ready until a handshake happens
    task automatic run_txn(input int c, input int hold, input bit rnd);
        logic [WIDTH:0]   exp;
        logic [WIDTH-1:0] held;
        int               guard;
        int               lat;
        bit               quiet;
        bit               hs;
        in_valid = 1'b1;
        cnt_in   = CNT_W'(c);
        guard = 0;
        while (!in_ready && guard < 50) begin
            tick();
            guard++;
        end
        check("in_ready_wait", 32'(in_ready), 32'd1);
        tick();
        exp_q.push_back(model(c));
        check("in_ready_after_accept", 32'(in_ready), 32'd0);
        // in_valid stays high and cnt_in churns; both must be ignored
        cnt_in = CNT_W'($urandom_range(0, 15));
        lat   = 0;
        quiet = 1'b1;
        while (!out_valid && lat < 40) begin
            if (out_data != '0 || in_ready || sat) quiet = 1'b0;
            tick();
            lat++;
            cnt_in = CNT_W'($urandom_range(0, 15));
        end
        in_valid = 1'b0;
        check("latency", 32'(lat), 32'(WIDTH));
        check("quiet_during_shift", 32'(quiet), 32'd1);
        if (exp_q.size() == 0) begin
            check("scoreboard_empty", 32'(exp_q.size()), 32'd1);
            exp = '0;
        end else begin
            exp = exp_q.pop_front();
        end
        check("data", 32'(out_data), 32'(exp[WIDTH-1:0]));
        check("sat", 32'(sat), 32'(exp[WIDTH]));
        check("popcount", 32'(popcount(out_data)), 32'(clamp(c)));
`ifdef THERMO_ENC_SELFCHECK_EN
        check("chk_err", 32'(chk_err), 32'd0);
`endif
        held = exp[WIDTH-1:0];
        for (int i = 0; i < hold; i++) begin
            out_ready = 1'b0;
            tick();
            check("hold_valid", 32'(out_valid), 32'd1);
            check("hold_data", 32'(out_data), 32'(held));
            check("hold_in_ready", 32'(in_ready), 32'd0);
        end
        if (rnd) begin
            guard = 0;
            hs    = 1'b0;
            while (!hs && guard < 30) begin
                out_ready = 1'($urandom_range(0, 1));
                hs = out_ready;
                tick();
                guard++;
                if (!hs) check("rnd_hold_data", 32'(out_data), 32'(held));
            end
            if (!hs) begin
                out_ready = 1'b1;
                tick();
            end
        end else begin
            out_ready = 1'b1;
            tick();
        end
        out_ready = 1'b0;
        check("valid_drop", 32'(out_valid), 32'd0);
        check("idle_bubble_ready", 32'(in_ready), 32'd1);
    endtask

    // Watchdog
    initial begin
        #500000;
        $display("FAIL watchdog simulation did not finish");
        $fatal(1, "watchdog");
    end

    // Directed sequence
    initial begin
        int seen;
        rst = 1'b1;
        repeat (3) tick();
        check("rst_in_ready", 32'(in_ready), 32'd0);
        check("rst_out_valid", 32'(out_valid), 32'd0);
        check("rst_out_data", 32'(out_data), 32'd0);
        check("rst_sat", 32'(sat), 32'd0);
        check("rst_state", 32'(dbg_state), 32'(ST_IDLE));
        rst = 1'b0;
        #1;
        check("post_rst_in_ready", 32'(in_ready), 32'd1);

        run_txn(0, 0, 1'b0);
        run_txn(5, 0, 1'b0);
        run_txn(8, 0, 1'b0);
        run_txn(12, 0, 1'b0);
        run_txn(3, 4, 1'b0);

        // Reset in the middle of SHIFT discards the word
        in_valid = 1'b1;
        cnt_in   = CNT_W'(6);
        tick();
        in_valid = 1'b0;
        tick();
        tick();
        rst = 1'b1;
        tick();
        check("midrst_in_ready", 32'(in_ready), 32'd0);
        check("midrst_out_valid", 32'(out_valid), 32'd0);
        check("midrst_state", 32'(dbg_state), 32'(ST_IDLE));
        rst = 1'b0;
        #1;
        check("midrst_release_ready", 32'(in_ready), 32'd1);
        seen = 0;
        for (int i = 0; i < 12; i++) begin
            if (out_valid) seen++;
            tick();
        end
        check("midrst_no_output", 32'(seen), 32'd0);
        run_txn(2, 0, 1'b0);

        // Back-to-back sweep with random out_ready
        for (int c = 0; c < 16; c++) run_txn(c, 0, 1'b1);

        check("scoreboard_drained", 32'(exp_q.size()), 32'd0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule : tb_thermo_enc_seq
